// File: rtl/rxm_bar_mem.sv
// rtl/rxm_bar_mem.sv - Avalon-MM burst slave backing one Rxm BAR with on-chip memory.
// Optional out-of-range checking when RXM_BAR_MEM_RANGE_CHK_EN is defined.
module rxm_bar_mem #(
  parameter int AVALON_ADDR_WIDTH = 32,
  parameter int CB_RXM_DATA_WIDTH = 64,
  parameter int DEPTH             = 256
) (
  input  logic                           Clk_i,
  input  logic                           Rst_i,
  input  logic                           RxmWrite_o,
  input  logic                           RxmRead_o,
  input  logic [AVALON_ADDR_WIDTH-1:0]   RxmAddress_o,
  input  logic [CB_RXM_DATA_WIDTH-1:0]   RxmWriteData_o,
  input  logic [CB_RXM_DATA_WIDTH/8-1:0] RxmByteEnable_o,
  input  logic [6:0]                     RxmBurstCount_o,
  output logic                           RxmWaitRequest_i,
  output logic [CB_RXM_DATA_WIDTH-1:0]   RxmReadData_i,
  output logic                           RxmReadDataValid_i,
  output logic                           RxmErr_i,
  input  logic                           ErrClr_i
);

  localparam int BE_W     = CB_RXM_DATA_WIDTH / 8;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int ADDR_LSB = $clog2(BE_W);
  localparam logic [CB_RXM_DATA_WIDTH-1:0] ERR_PAT =
    CB_RXM_DATA_WIDTH'({((CB_RXM_DATA_WIDTH + 63) / 64){64'hDEAD_BEEF_DEAD_BEEF}});

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx;
  logic [6:0]             remaining;
  logic                   oor_q;
  logic                   wait_q;
  logic                   pipe_v, pipe_last;
  logic                   out_v, out_last;
  logic [CB_RXM_DATA_WIDTH-1:0] mem_q, out_data;
  logic [CB_RXM_DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] addr_idx;
  logic [6:0]       bc_eff;
  logic             cmd_oor;
  logic             wr_en, wr_start, wr_beat, rd_start, rd_issue;
  logic [IDX_W-1:0] wr_idx;
  logic             unused_bits;

  assign addr_idx    = RxmAddress_o[ADDR_LSB+IDX_W-1:ADDR_LSB];
  assign bc_eff      = (RxmBurstCount_o == 7'd0) ? 7'd1 : RxmBurstCount_o;
  assign unused_bits = ^{ErrClr_i, RxmAddress_o};

`ifdef RXM_BAR_MEM_RANGE_CHK_EN
  assign cmd_oor = |RxmAddress_o[AVALON_ADDR_WIDTH-1:ADDR_LSB+IDX_W];
`else
  assign cmd_oor = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_idx    = idx;
    wr_start  = 1'b0;
    wr_beat   = 1'b0;
    rd_start  = 1'b0;
    rd_issue  = 1'b0;
    case (state)
      IDLE: begin
        // wait_q is still high for one edge after reset release
        if (!wait_q) begin
          if (RxmWrite_o) begin
            wr_start = 1'b1;
            wr_en    = !cmd_oor;
            wr_idx   = addr_idx;
            if (bc_eff != 7'd1) state_nxt = WRITE;
          end else if (RxmRead_o) begin
            rd_start  = 1'b1;
            state_nxt = READ;
          end
        end
      end
      WRITE: begin
        if (RxmWrite_o) begin
          wr_beat = 1'b1;
          wr_en   = !oor_q;
          if (remaining == 7'd1) state_nxt = IDLE;
        end
      end
      READ: begin
        rd_issue = (remaining != 7'd0);
        if (out_v && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state     <= IDLE;
      wait_q    <= 1'b1;
      idx       <= '0;
      remaining <= '0;
      oor_q     <= 1'b0;
      pipe_v    <= 1'b0;
      pipe_last <= 1'b0;
      out_v     <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state  <= state_nxt;
      wait_q <= (state_nxt == READ);
      if (wr_start) begin
        idx       <= addr_idx + IDX_W'(1);
        remaining <= bc_eff - 7'd1;
        oor_q     <= cmd_oor;
      end else if (rd_start) begin
        idx       <= addr_idx;
        remaining <= bc_eff;
        oor_q     <= cmd_oor;
      end else if (wr_beat || rd_issue) begin
        idx       <= idx + IDX_W'(1);
        remaining <= remaining - 7'd1;
      end
      pipe_v    <= rd_issue;
      pipe_last <= rd_issue && (remaining == 7'd1);
      out_v     <= pipe_v;
      out_last  <= pipe_v && pipe_last;
      out_data  <= pipe_v ? mem_q : '0;
    end
  end

  // Memory array and its read register carry no reset
  always_ff @(posedge Clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (RxmByteEnable_o[b]) mem[wr_idx][b*8 +: 8] <= RxmWriteData_o[b*8 +: 8];
      end
    end
    if (rd_issue) mem_q <= oor_q ? ERR_PAT : mem[idx];
  end

`ifdef RXM_BAR_MEM_RANGE_CHK_EN
  logic err_q;
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i)                               err_q <= 1'b0;
    else if ((wr_start || rd_start) && cmd_oor) err_q <= 1'b1;
    else if (ErrClr_i)                       err_q <= 1'b0;
  end
  assign RxmErr_i = err_q;
`else
  assign RxmErr_i = 1'b0;
`endif

  assign RxmWaitRequest_i   = wait_q;
  assign RxmReadData_i      = out_data;
  assign RxmReadDataValid_i = out_v;

endmodule

// File: doc/rxm_bar_mem.md
Name: rxm_bar_mem

Overview:
- Avalon-MM burst slave that terminates one Rxm BAR master port of the PCIe RX control path (tlp_rx_cntrl Rxm_<n>).
- Backs the BAR with an on-chip word-addressed memory of DEPTH x CB_RXM_DATA_WIDTH bits.
- Services single-beat and burst writes and reads from inbound memory TLPs.
- Drives WaitRequest/ReadData/ReadDataValid back to the RX control block.

Parameters:
AVALON_ADDR_WIDTH, 32, byte-address width of RxmAddress_o
CB_RXM_DATA_WIDTH, 64, data beat width; byte enables = CB_RXM_DATA_WIDTH/8
DEPTH, 256, memory words; power of 2; IDX_W = log2(DEPTH), ADDR_LSB = log2(CB_RXM_DATA_WIDTH/8)

Ports:
Clk_i  in  1  Avalon clock
Rst_i  in  1  asynchronous reset, active-high
RxmWrite_o  in  1  write request/beat
RxmRead_o  in  1  read command
RxmAddress_o  in  AVALON_ADDR_WIDTH  byte address, first beat only
RxmWriteData_o  in  CB_RXM_DATA_WIDTH  write data
RxmByteEnable_o  in  CB_RXM_DATA_WIDTH/8  byte enables, per beat
RxmBurstCount_o  in  7  beats, 1..64; first beat only
RxmWaitRequest_i  out  1  slave stall
RxmReadData_i  out  CB_RXM_DATA_WIDTH  read data
RxmReadDataValid_i  out  1  read beat valid
RxmErr_i  out  1  sticky out-of-range flag
ErrClr_i  in  1  clears RxmErr_i

Behaviour:
- Clock and reset: one clock Clk_i; Rst_i asynchronous, active-high. Memory contents are not reset.
- Reset values:
  - RxmWaitRequest_i=1; deasserts on the first clock edge after Rst_i falls.
  - RxmReadDataValid_i=0, RxmReadData_i=0, RxmErr_i=0, state=IDLE, beat counter=0.
- Word index = RxmAddress_o[ADDR_LSB+IDX_W-1:ADDR_LSB], latched on the first beat. It increments by 1 per beat and wraps mod DEPTH (DEPTH-1 -> 0).
- A burst count of 0 is treated as 1.
- A transfer is accepted on an edge where the request is high and RxmWaitRequest_i=0.
- States:
  - IDLE: WaitRequest=0.
    - Accepted write: write beat 0 with byte enables, latch index+1 and remaining = BC-1. Go to WRITE if remaining>0, else stay in IDLE.
    - Accepted read: latch index and BC, go to READ; WaitRequest registered to 1 on the same edge.
    - RxmWrite_o and RxmRead_o both high: write wins; the read is dropped (no data returned).
  - WRITE: WaitRequest=0.
    - Each edge with RxmWrite_o=1 writes one beat at the current index; index+1, remaining-1.
    - RxmWrite_o=0 is a master bubble: no change.
    - RxmRead_o is ignored.
    - After the last beat, go to IDLE.
  - READ: WaitRequest=1.
    - Synchronous memory read pipeline, one read issued per cycle.
    - Command accepted at edge E0 -> RxmReadDataValid_i high for exactly BC consecutive cycles, starting after edge E2. The first beat has 2-cycle latency.
    - RxmReadData_i holds the beat data while valid and 0 otherwise.
    - Go to IDLE on the edge after the last beat is presented. WaitRequest=0 in the cycle following the last valid beat.
- Reset mid-burst: the burst is abandoned, the state returns to IDLE, and pending read beats are never presented.
- Partial-byte writes modify only the enabled bytes. A beat with all enables 0 still counts as a beat.

Optional Feature:
Macro RXM_BAR_MEM_RANGE_CHK_EN.
- With the macro:
  - A command is out-of-range when RxmAddress_o[AVALON_ADDR_WIDTH-1:ADDR_LSB+IDX_W] != 0 on its first beat.
  - Out-of-range writes: all beats accepted with normal handshake, memory unmodified.
  - Out-of-range reads: normal timing, every beat returns the pattern 64'hDEAD_BEEF_DEAD_BEEF (truncated/replicated to width).
  - RxmErr_i set on the acceptance edge.
  - ErrClr_i=1 clears RxmErr_i; set has priority over a simultaneous clear.
- Without the macro:
  - Upper address bits are ignored (aliasing).
  - RxmErr_i is tied 0 and ErrClr_i is unused.

Test Plan:
- Reset release -> RxmWaitRequest_i 1 then 0 after one edge. Single write to addr 0x10, data 0x0123456789ABCDEF, BE 0xFF. Read addr 0x10, BC=1 -> one valid beat 2 cycles after accept with that data. WaitRequest low the cycle after.
- Burst write BC=4 at 0x0, data 1..4, with a 2-cycle RxmWrite_o bubble after beat 2. Then write BE=0x0F, data 0xFFFFFFFFFFFFFFFF to 0x8. Read BC=4 at 0x0 -> 1, 0x00000000FFFFFFFF, 3, 4 on consecutive cycles.
- Wrap: DEPTH=256, write BC=3 at word 254 (addr 0x7F0) with data A, B, C. Read word 0 -> C; read BC=2 at 0x7F0 -> A, B.
- Simultaneous RxmWrite_o=1 and RxmRead_o=1 in IDLE -> write performed, no RxmReadDataValid_i pulse. Read BC=64 -> 64 contiguous valid beats, WaitRequest high throughout.
- Assert Rst_i during beat 3 of a BC=8 read -> RxmReadDataValid_i drops immediately and stays 0; WaitRequest 1, then 0 after release. The next read returns correct data.
- RANGE_CHK_EN: write 0x55 at addr 0x1000 (DEPTH=256) -> memory word 0 unchanged, RxmErr_i=1. Read 0x1000 -> DEADBEEF pattern. Pulse ErrClr_i -> RxmErr_i=0.
